apb_slave_regfile: RTL and testbench
====================================

// Module: apb_slave_regfile
// PURPOSE
//  APB completer (slave) at the far end of the AHB-to-APB bridge FSM; one instance per Pselx bit.
//  Holds NREGS x 32-bit read/write registers and decodes Paddr against BASE_ADDR.
//  Inserts WAIT_STATES access-phase wait cycles via Pready, and returns read data on Prdata.
// PARAMETERS
//  NREGS        16            number of 32-bit registers (power of 2, 2..256)
//  BASE_ADDR    32'h8000_0000 byte address of register 0; must be aligned to NREGS*4
//  WAIT_STATES  0             access-phase wait cycles before Pready=1 (0..7)
// PORTS
//  clk      in   1   single clock, all logic on posedge
//  rst      in   1   synchronous active-low reset
//  Psel     in   1   this completer's select (one bit of the bridge's Pselx)
//  Penable  in   1   APB access-phase strobe
//  Pwrite   in   1   1=write, 0=read
//  Paddr    in   32  byte address
//  Pwdata   in   32  write data
//  Prdata   out  32  read data, registered; valid while Pready=1 on a read
//  Pready   out  1   transfer-complete strobe, registered
//  Pslverr  out  1   error response (only with APB_SLV_PSLVERR_EN)
// BEHAVIOUR
//  - Reset (rst=0 at posedge): state=IDLE; Pready=0; Prdata=0; Pslverr=0; wait cnt=0; all regs=0.
//  - Hit: Paddr[1:0]==0 and BASE_ADDR <= Paddr < BASE_ADDR+NREGS*4.
//    Register index = (Paddr-BASE_ADDR)>>2.
//  - FSM states: IDLE, WAIT, READY.
//  - Setup detection: in IDLE or READY, a cycle with Psel=1, Penable=0.
//    * Latch Paddr, Pwrite, Pwdata and hit.
//    * If WAIT_STATES==0: go to READY; else go to WAIT with cnt=WAIT_STATES-1.
//  - WAIT: while Psel&Penable, cnt decrements each cycle. When cnt==0 at the edge, go to READY.
//  - READY: Pready=1 for exactly one cycle; this is the completion cycle.
//    * Next state is WAIT/READY if a new setup is present in this same cycle; otherwise IDLE.
//  - Transfer latency: with a setup at cycle T, Pready=1 at cycle T+1+WAIT_STATES.
//  - Write commit: the latched Pwdata is stored at the edge entering READY, only if hit.
//    Misses are silently dropped.
//  - Read data: Prdata is loaded at the edge entering READY.
//    * Value = reg[index] on a hit, 32'h0 on a miss.
//    * Prdata holds until the next read loads it; writes do not change Prdata.
//  - Read of the register being written by the immediately preceding transfer returns the new value.
//  - Pready is 0 in every cycle other than READY.
//  - Back-to-back transfers (the bridge's WENABLEP->WRITEP path): setup in the READY cycle is accepted.
//    No idle cycle is required.
//  - Protocol violations:
//    * Psel&Penable seen in IDLE (no setup): ignored, stay IDLE, Pready=0.
//    * Psel deasserted in WAIT: abort to IDLE, no write, Prdata unchanged.
//  - Reset mid-transfer: an in-flight write is discarded; all outputs return to reset values next cycle.
//  - Pwdata, Pwrite and Paddr changes during WAIT are ignored; the setup-latched copies are used.
// CONFIGURATION
//  APB_SLV_PSLVERR_EN defined:
//    * Pslverr port exists; Pslverr=1 in the READY cycle of a miss, else 0.
//    * Pslverr is registered alongside Pready; reset value 0.
//  APB_SLV_PSLVERR_EN undefined:
//    * Pslverr port absent.
//    * Misses are dropped silently; miss reads return 0.
// TESTING
//  1. Write then read, WAIT_STATES=0:
//     write 32'hDEAD_BEEF to 32'h8000_0008, then read the same address.
//     -> Pready at T+1 each time; second transfer Prdata=32'hDEAD_BEEF.
//  2. Wait states, WAIT_STATES=3: setup at T.
//     -> Pready=0 for T+1..T+3 and 1 at T+4; write visible on readback.
//  3. Back-to-back writes: 32'h1 to idx0 and 32'h2 to idx1, setup issued in the READY cycle.
//     -> both commit; readbacks return 1 and 2.
//  4. Miss: write to 32'h8000_0040 (NREGS=16), then misaligned 32'h8000_0002.
//     -> no register changes; read returns 0; Pslverr=1 only with the macro.
//  5. Abort: drop Psel in WAIT during a write of 32'h55 (WAIT_STATES=2).
//     -> IDLE, Pready never 1, register keeps its old value.
//  6. Reset in WAIT: rst=0 for one cycle.
//     -> Pready=0, Prdata=0, all registers read back 0 afterwards.

Source files
------------

// File: rtl/apb_slave_regfile.sv
// apb_slave_regfile: APB completer holding NREGS x 32-bit read/write registers.
// Decodes Paddr against BASE_ADDR, inserts WAIT_STATES access-phase wait cycles
// before a one-cycle Pready, and returns registered read data on Prdata.
//
// Ports:
//   clk      single clock, all logic on posedge
//   rst      synchronous active-low reset
//   Psel     completer select
//   Penable  access-phase strobe
//   Pwrite   1 = write, 0 = read
//   Paddr    byte address
//   Pwdata   write data
//   Prdata   registered read data, valid while Pready=1 on a read
//   Pready   registered transfer-complete strobe
//   Pslverr  registered error response on a miss (only with APB_SLV_PSLVERR_EN)
//
// Build option: define APB_SLV_PSLVERR_EN to add the Pslverr port.
module apb_slave_regfile #(
  parameter int unsigned NREGS       = 16,
  parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        Psel,
  input  logic        Penable,
  input  logic        Pwrite,
  input  logic [31:0] Paddr,
  input  logic [31:0] Pwdata,
  output logic [31:0] Prdata,
  output logic        Pready
`ifdef APB_SLV_PSLVERR_EN
  ,
  output logic        Pslverr
`endif
);

  localparam int unsigned IdxW     = $clog2(NREGS);
  localparam logic [2:0]  WaitInit = 3'(WAIT_STATES - 1);

  typedef enum logic [1:0] {StIdle, StWait, StReady} state_e;

  state_e        state_q, state_d;
  logic [2:0]    cnt_q, cnt_d;
  logic [31:0]   addr_q, wdata_q;
  logic          write_q;
  logic [31:0]   prdata_q;
  logic          pready_q;
  logic [31:0]   regs_q [NREGS];

  logic          setup;
  logic          latch;
  logic          enter_ready;
  logic [31:0]   cur_addr, cur_wdata, cur_off;
  logic          cur_write, cur_hit;
  logic [IdxW-1:0] cur_idx;

  assign setup = Psel && !Penable;

  // With zero wait states the transfer completes straight out of setup, so the
  // live bus values are used; otherwise the setup-latched copies are used and
  // bus changes during WAIT have no effect. The hit flag is derived from the
  // latched address, which is equivalent to latching the hit itself.
  always_comb begin
    if (state_q == StWait) begin
      cur_addr  = addr_q;
      cur_wdata = wdata_q;
      cur_write = write_q;
    end else begin
      cur_addr  = Paddr;
      cur_wdata = Pwdata;
      cur_write = Pwrite;
    end
    cur_off = cur_addr - BASE_ADDR;
    cur_hit = (cur_addr[1:0] == 2'b00) && (cur_addr >= BASE_ADDR) && (cur_off < NREGS * 4);
    cur_idx = cur_off[IdxW+1:2];
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    latch       = 1'b0;
    enter_ready = 1'b0;
    unique case (state_q)
      StIdle, StReady: begin
        // A new setup in the READY cycle is accepted (back-to-back transfers).
        if (setup) begin
          latch = 1'b1;
          if (WAIT_STATES == 0) begin
            state_d     = StReady;
            enter_ready = 1'b1;
          end else begin
            state_d = StWait;
            cnt_d   = WaitInit;
          end
        end else begin
          state_d = StIdle;
        end
      end
      StWait: begin
        if (!Psel) begin
          state_d = StIdle;  // abort: nothing commits
        end else if (Penable) begin
          if (cnt_q == 3'd0) begin
            state_d     = StReady;
            enter_ready = 1'b1;
          end else begin
            cnt_d = cnt_q - 3'd1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

`ifdef APB_SLV_PSLVERR_EN
  logic pslverr_q;
  always_ff @(posedge clk) begin
    if (!rst) begin
      pslverr_q <= 1'b0;
    end else begin
      pslverr_q <= enter_ready && !cur_hit;
    end
  end
  assign Pslverr = pslverr_q;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= StIdle;
      cnt_q    <= 3'd0;
      addr_q   <= '0;
      wdata_q  <= '0;
      write_q  <= 1'b0;
      prdata_q <= '0;
      pready_q <= 1'b0;
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      pready_q <= enter_ready;
      if (latch) begin
        addr_q  <= Paddr;
        wdata_q <= Pwdata;
        write_q <= Pwrite;
      end
      if (enter_ready) begin
        if (cur_write) begin
          if (cur_hit) begin
            regs_q[cur_idx] <= cur_wdata;
          end
        end else begin
          prdata_q <= cur_hit ? regs_q[cur_idx] : 32'h0;
        end
      end
    end
  end

  assign Prdata = prdata_q;
  assign Pready = pready_q;

endmodule

// File: tb/tb_apb_slave_regfile.sv
// Scoreboard bench for apb_slave_regfile: one instance with no wait states and
// one with three. The driver pushes the hand-computed response of every
// completed transfer; a monitor pops and compares whenever Pready is seen.
module tb_apb_slave_regfile;

  localparam int unsigned Ws0 = 0;
  localparam int unsigned Ws1 = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [1:0]  psel = '0, penable = '0, pwrite = '0;
  logic [31:0] paddr [2];
  logic [31:0] pwdata [2];
  logic [31:0] prdata [2];
  logic [1:0]  pready;
  logic [1:0]  pslverr;

  typedef struct {
    int          d;
    bit          is_read;
    logic [31:0] rdata;
    bit          err;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] held [2];
  int          n_vec = 0;
  int          n_bad = 0;

  always #5 clk = ~clk;

  apb_slave_regfile #(.NREGS(16), .BASE_ADDR(32'h8000_0000), .WAIT_STATES(Ws0)) u_dut0 (
    .clk     (clk),
    .rst     (rst),
    .Psel    (psel[0]),
    .Penable (penable[0]),
    .Pwrite  (pwrite[0]),
    .Paddr   (paddr[0]),
    .Pwdata  (pwdata[0]),
    .Prdata  (prdata[0]),
    .Pready  (pready[0])
`ifdef APB_SLV_PSLVERR_EN
    ,
    .Pslverr (pslverr[0])
`endif
  );

  apb_slave_regfile #(.NREGS(16), .BASE_ADDR(32'h8000_0000), .WAIT_STATES(Ws1)) u_dut1 (
    .clk     (clk),
    .rst     (rst),
    .Psel    (psel[1]),
    .Penable (penable[1]),
    .Pwrite  (pwrite[1]),
    .Paddr   (paddr[1]),
    .Pwdata  (pwdata[1]),
    .Prdata  (prdata[1]),
    .Pready  (pready[1])
`ifdef APB_SLV_PSLVERR_EN
    ,
    .Pslverr (pslverr[1])
`endif
  );

`ifndef APB_SLV_PSLVERR_EN
  assign pslverr = '0;
`endif

  // Monitor: every Pready must match the oldest outstanding expectation.
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (pready[d]) begin
        n_vec++;
        if (sb_q.size() == 0) begin
          n_bad++;
          $display("FAIL unexpected_pready dut%0d: Pready=1 with no transfer outstanding", d);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          if (e.d != d || prdata[d] !== e.rdata) begin
            n_bad++;
            $display("FAIL resp dut%0d: got Prdata=%h, required dut%0d Prdata=%h (read=%0b)",
                     d, prdata[d], e.d, e.rdata, e.is_read);
          end
`ifdef APB_SLV_PSLVERR_EN
          n_vec++;
          if (pslverr[d] !== e.err) begin
            n_bad++;
            $display("FAIL pslverr dut%0d: got %b, required %b", d, pslverr[d], e.err);
          end
`endif
        end
      end
    end
  end

  function automatic int unsigned ws_of(input int d);
    return (d == 0) ? Ws0 : Ws1;
  endfunction

  // Drives a setup from the current time (mid-cycle), then the access phase,
  // and returns at the negedge where Pready is seen. Calling it again right
  // away issues the next setup inside the READY cycle.
  task automatic xfer(input int d, input bit wr, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [31:0] exp_rd, input bit exp_err);
    exp_t e;
    int   lat;
    e.d       = d;
    e.is_read = !wr;
    e.rdata   = wr ? held[d] : exp_rd;
    e.err     = exp_err;
    if (!wr) held[d] = exp_rd;
    sb_q.push_back(e);
    psel[d] = 1'b1; penable[d] = 1'b0; pwrite[d] = wr; paddr[d] = addr; pwdata[d] = wdata;
    @(posedge clk); #1;
    penable[d] = 1'b1;
    lat = 0;
    forever begin
      @(negedge clk);
      if (pready[d]) break;
      lat++;
      if (lat > 20) break;
      // Junk on the bus during WAIT must be ignored.
      pwrite[d] = !wr; paddr[d] = addr ^ 32'h4; pwdata[d] = ~wdata;
    end
    n_vec++;
    if (lat != int'(ws_of(d))) begin
      n_bad++;
      $display("FAIL latency dut%0d addr=%h: got %0d wait cycles, required %0d",
               d, addr, lat, ws_of(d));
    end
  endtask

  task automatic idle(input int d);
    @(posedge clk); #1;
    psel[d] = 1'b0; penable[d] = 1'b0;
  endtask

  task automatic check_zero(input string name);
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      n_vec += 2;
      if (pready[d] !== 1'b0) begin
        n_bad++;
        $display("FAIL %s_pready dut%0d: got %b, required 0", name, d, pready[d]);
      end
      if (prdata[d] !== 32'h0) begin
        n_bad++;
        $display("FAIL %s_prdata dut%0d: got %h, required 00000000", name, d, prdata[d]);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int d = 0; d < 2; d++) begin
      paddr[d] = '0; pwdata[d] = '0; held[d] = '0;
    end
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    check_zero("reset");
    @(posedge clk); #1;

    // Write then read, no wait states.
    xfer(0, 1'b1, 32'h8000_0008, 32'hDEAD_BEEF, 32'h0, 1'b0); idle(0);
    xfer(0, 1'b0, 32'h8000_0008, 32'h0, 32'hDEAD_BEEF, 1'b0); idle(0);

    // Back-to-back chain, each setup issued in the READY cycle.
    xfer(0, 1'b1, 32'h8000_0000, 32'h1, 32'h0, 1'b0);
    xfer(0, 1'b1, 32'h8000_0004, 32'h2, 32'h0, 1'b0);
    xfer(0, 1'b0, 32'h8000_0000, 32'h0, 32'h1, 1'b0);
    xfer(0, 1'b0, 32'h8000_0004, 32'h0, 32'h2, 1'b0); idle(0);

    // Misses: past the top, misaligned, below the base; last register is a hit.
    xfer(0, 1'b1, 32'h8000_0040, 32'h1234, 32'h0, 1'b1); idle(0);
    xfer(0, 1'b1, 32'h8000_0002, 32'h5555, 32'h0, 1'b1); idle(0);
    xfer(0, 1'b0, 32'h8000_0040, 32'h0, 32'h0, 1'b1);    idle(0);
    xfer(0, 1'b0, 32'h8000_0000, 32'h0, 32'h1, 1'b0);    idle(0);
    xfer(0, 1'b0, 32'h7FFF_FFFC, 32'h0, 32'h0, 1'b1);    idle(0);
    xfer(0, 1'b1, 32'h8000_003C, 32'hA5, 32'h0, 1'b0);   idle(0);
    xfer(0, 1'b0, 32'h8000_003C, 32'h0, 32'hA5, 1'b0);   idle(0);
    xfer(0, 1'b0, 32'h8000_0008, 32'h0, 32'hDEAD_BEEF, 1'b0); idle(0);

    // Three wait states, with junk on the bus during WAIT.
    xfer(1, 1'b1, 32'h8000_0010, 32'hCAFE_F00D, 32'h0, 1'b0); idle(1);
    xfer(1, 1'b0, 32'h8000_0010, 32'h0, 32'hCAFE_F00D, 1'b0); idle(1);
    xfer(1, 1'b1, 32'h8000_0014, 32'h77, 32'h0, 1'b0);
    xfer(1, 1'b0, 32'h8000_0014, 32'h0, 32'h77, 1'b0);         idle(1);
    xfer(1, 1'b1, 32'h8000_0020, 32'h11, 32'h0, 1'b0);         idle(1);

    // Abort: Psel dropped in WAIT; no Pready and no write.
    psel[1] = 1'b1; penable[1] = 1'b0; pwrite[1] = 1'b1;
    paddr[1] = 32'h8000_0020; pwdata[1] = 32'h55;
    @(posedge clk); #1 penable[1] = 1'b1;
    @(posedge clk); #1 psel[1] = 1'b0; penable[1] = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    xfer(1, 1'b0, 32'h8000_0020, 32'h0, 32'h11, 1'b0); idle(1);

    // Reset while a write sits in WAIT.
    psel[1] = 1'b1; penable[1] = 1'b0; pwrite[1] = 1'b1;
    paddr[1] = 32'h8000_0024; pwdata[1] = 32'h99;
    @(posedge clk); #1 penable[1] = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #1 rst = 1'b1; psel[1] = 1'b0; penable[1] = 1'b0;
    held[0] = '0; held[1] = '0;
    check_zero("midreset");
    @(posedge clk); #1;
    xfer(1, 1'b0, 32'h8000_0024, 32'h0, 32'h0, 1'b0); idle(1);
    xfer(1, 1'b0, 32'h8000_0010, 32'h0, 32'h0, 1'b0); idle(1);
    xfer(0, 1'b0, 32'h8000_0008, 32'h0, 32'h0, 1'b0); idle(0);
    xfer(0, 1'b0, 32'h8000_003C, 32'h0, 32'h0, 1'b0); idle(0);

    repeat (4) @(posedge clk);
    n_vec++;
    if (sb_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d expected responses never seen, required 0", sb_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
